// File: rtl/freq_gate_counter.sv
// freq_gate_counter: gated BCD edge counter for the TTL frequency meter, latching one result per window
module freq_gate_counter #(
  parameter int CLK_HZ      = 50000000,
  parameter int GATE_CYCLES = CLK_HZ,
  parameter int DIGITS      = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clock_text,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                overflow,
  output logic                done,
  output logic                gate_active
);
  localparam int GW = GATE_CYCLES > 1 ? $clog2(GATE_CYCLES) : 1;
  typedef enum logic [1:0] {CLEAR, GATE, LATCH} state_t;
  state_t state, nxt;
  logic s1, s2, s3, pulse;
  logic [GW-1:0] gcnt;
  logic [4*DIGITS-1:0] work, inc;
  logic wovf, all9, c, clr, cnt, lat;
  assign pulse = s2 & ~s3;
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= CLEAR;
    else state <= nxt;
  // next state: one CLEAR cycle, GATE_CYCLES of GATE, one LATCH cycle
  always_comb begin
    nxt = state == CLEAR ? GATE :
          state == GATE  ? (gcnt == GW'(GATE_CYCLES - 1) ? LATCH : GATE) :
          CLEAR;
  end
  // state decode into datapath strobes
  always_comb begin
    clr = state == CLEAR;
    cnt = state == GATE;
    lat = state == LATCH;
  end
  // decimal increment with ripple carry; all9 marks the saturated value
  always_comb begin
    inc = work;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      inc[4*k+:4] = c ? (work[4*k+:4] == 4'd9 ? 4'd0 : work[4*k+:4] + 4'd1) : work[4*k+:4];
      c = c & (work[4*k+:4] == 4'd9);
    end
    all9 = c;
  end
  // two-flop synchroniser plus delay stage for rising-edge detection
  always_ff @(posedge clock or negedge reset)
    if (!reset) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {clock_text, s1, s2};
  // working counter and gate timer; edges outside GATE are dropped
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      work <= '0;
      wovf <= 1'b0;
      gcnt <= '0;
    end else if (clr) begin
      work <= '0;
      wovf <= 1'b0;
      gcnt <= '0;
    end else if (cnt) begin
      gcnt <= gcnt + 1'b1;
      if (pulse && all9) wovf <= 1'b1;
      else if (pulse) work <= inc;
    end
  // result latch, done pulse and registered gate flag
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      bcd_out     <= '0;
      overflow    <= 1'b0;
      done        <= 1'b0;
      gate_active <= 1'b0;
    end else begin
      if (lat) begin
        bcd_out  <= work;
        overflow <= wovf;
      end
      done        <= lat;
      gate_active <= nxt == GATE;
    end
endmodule

// File: tb/tb_freq_gate_counter.sv
// tb_freq_gate_counter: scoreboard bench for freq_gate_counter across three parameter sets
module tb_freq_gate_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn0 = 1'b0, rstn1 = 1'b0, rstn2 = 1'b0;
  logic ct0 = 1'b0, ct1 = 1'b0, ct2 = 1'b0;
  int per0 = 0, per1 = 0;
  logic [31:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [15:0] bcd_c;
  logic ovf_a, ovf_b, ovf_c, done_a, done_b, done_c, gate_a, gate_b, gate_c;
  freq_gate_counter #(.GATE_CYCLES(1000), .DIGITS(8)) u_a (
    .clock(clk), .reset(rstn0), .clock_text(ct0), .bcd_out(bcd_a),
    .overflow(ovf_a), .done(done_a), .gate_active(gate_a));
  freq_gate_counter #(.GATE_CYCLES(1000), .DIGITS(2)) u_b (
    .clock(clk), .reset(rstn1), .clock_text(ct1), .bcd_out(bcd_b),
    .overflow(ovf_b), .done(done_b), .gate_active(gate_b));
  freq_gate_counter #(.GATE_CYCLES(5000), .DIGITS(4)) u_c (
    .clock(clk), .reset(rstn2), .clock_text(ct2), .bcd_out(bcd_c),
    .overflow(ovf_c), .done(done_c), .gate_active(gate_c));
  typedef struct {int dut; bit skip; logic [31:0] bcd; logic ovf;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(input int k, input bit s, input logic [31:0] b, input logic o);
    exp_t e;
    e.dut = k;
    e.skip = s;
    e.bcd = b;
    e.ovf = o;
    sb.push_back(e);
  endtask
  task automatic score(input int k, input logic [31:0] b, input logic o);
    exp_t e;
    if (sb.size() == 0) check("unexpected_done", 32'(k), 32'hffffffff);
    else begin
      e = sb.pop_front();
      check("sb_dut", 32'(k), 32'(e.dut));
      if (!e.skip) begin
        check("bcd", b, e.bcd);
        check("ovf", {31'b0, o}, {31'b0, e.ovf});
      end
    end
  endtask
  function automatic logic dn(input int k);
    return k == 0 ? done_a : k == 1 ? done_b : done_c;
  endfunction
  task automatic wait_done(input int k, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dn(k) && n < budget);
    if (!dn(k)) check("done_timeout", {31'b0, dn(k)}, 32'd1);
  endtask
  task automatic next_done(input int k, input int period);
    int n;
    wait_done(k, period + 100, n);
    check("done_period", 32'(n), 32'(period));
  endtask
  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      ct2 = 1'b1;
      repeat (2) @(negedge clk);
      ct2 = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask
  always @(negedge clk) begin
    if (done_a) score(0, bcd_a, ovf_a);
    if (done_b) score(1, {24'h0, bcd_b}, ovf_b);
    if (done_c) score(2, {16'h0, bcd_c}, ovf_c);
  end
  initial forever begin
    if (per0 == 0) begin
      ct0 = 1'b0;
      @(negedge clk);
    end else begin
      ct0 = 1'b1;
      repeat (per0 / 2) @(negedge clk);
      ct0 = 1'b0;
      repeat (per0 - per0 / 2) @(negedge clk);
    end
  end
  initial forever begin
    if (per1 == 0) begin
      ct1 = 1'b0;
      @(negedge clk);
    end else begin
      ct1 = 1'b1;
      repeat (per1 / 2) @(negedge clk);
      ct1 = 1'b0;
      repeat (per1 - per1 / 2) @(negedge clk);
    end
  end
  initial begin
    int n, first, gcount, dcyc;
    repeat (5) @(negedge clk);
    check("rst_bcd", bcd_a, 32'h0);
    check("rst_ovf", {31'b0, ovf_a}, 32'h0);
    check("rst_done", {31'b0, done_a}, 32'h0);
    check("rst_gate", {31'b0, gate_a}, 32'h0);
    push(0, 1'b0, 32'h0, 1'b0);
    rstn0 = 1'b1;
    first = -1;
    gcount = 0;
    dcyc = -1;
    for (int c = 1; c <= 1003; c++) begin
      @(negedge clk);
      if (gate_a && first < 0) first = c;
      if (gate_a && c <= 1002) gcount++;
      if (done_a && dcyc < 0) begin
        dcyc = c;
        per0 = 100;
        push(0, 1'b0, 32'h10, 1'b0);
        push(0, 1'b0, 32'h10, 1'b0);
      end
    end
    check("gate_rise", 32'(first), 32'd1);
    check("gate_len", 32'(gcount), 32'd1000);
    check("first_done", 32'(dcyc), 32'd1002);
    check("done_width", {31'b0, done_a}, 32'h0);
    wait_done(0, 1100, n);
    check("done_period", 32'(n + 1), 32'd1002);
    next_done(0, 1002);
    per0 = 4;
    push(0, 1'b1, 32'h0, 1'b0);
    push(0, 1'b0, 32'h250, 1'b0);
    push(0, 1'b0, 32'h250, 1'b0);
    repeat (3) next_done(0, 1002);
    per0 = 1000;
    push(0, 1'b1, 32'h0, 1'b0);
    push(0, 1'b0, 32'h1, 1'b0);
    push(0, 1'b0, 32'h1, 1'b0);
    repeat (3) next_done(0, 1002);
    per0 = 4;
    push(0, 1'b1, 32'h0, 1'b0);
    next_done(0, 1002);
    repeat (500) @(negedge clk);
    check("mid_gate", {31'b0, gate_a}, 32'h1);
    rstn0 = 1'b0;
    per0 = 0;
    #1;
    check("async_bcd", bcd_a, 32'h0);
    check("async_ovf", {31'b0, ovf_a}, 32'h0);
    check("async_done", {31'b0, done_a}, 32'h0);
    check("async_gate", {31'b0, gate_a}, 32'h0);
    repeat (5) @(negedge clk);
    rstn0 = 1'b1;
    per0 = 4;
    push(0, 1'b0, 32'h250, 1'b0);
    next_done(0, 1002);
    rstn0 = 1'b0;
    per0 = 0;
    rstn1 = 1'b1;
    per1 = 4;
    push(1, 1'b0, 32'h99, 1'b1);
    push(1, 1'b0, 32'h99, 1'b1);
    repeat (2) next_done(1, 1002);
    per1 = 0;
    push(1, 1'b1, 32'h0, 1'b0);
    push(1, 1'b0, 32'h0, 1'b0);
    repeat (2) next_done(1, 1002);
    rstn1 = 1'b0;
    rstn2 = 1'b1;
    push(2, 1'b0, 32'h0, 1'b0);
    next_done(2, 5002);
    push(2, 1'b0, 32'h1099, 1'b0);
    burst(1099);
    wait_done(2, 5100, n);
    push(2, 1'b0, 32'h1100, 1'b0);
    burst(1100);
    wait_done(2, 5100, n);
    rstn2 = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
